sar_logic: RTL and testbench



---
 rtl/sar_logic_pkg.sv | 21 ++
 rtl/sar_logic_ptr.sv | 38 +++
 rtl/sar_logic.sv | 172 +++++++++++++++++
 tb/tb_sar_logic.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sar_logic_pkg.sv
// -----------------------------------------------------------------------------
// sar_logic_pkg
// Shared types and constants for the SAR ADC controller.
//   state_t      : controller phases (IDLE, SAMPLE, SETTLE, COMPARE, DONE)
//   STATE_W      : width of the state encoding
//   SAMPLE_CNT_W : width of the sample-phase down-counter
// -----------------------------------------------------------------------------
package sar_logic_pkg;

  localparam int STATE_W      = 3;
  localparam int SAMPLE_CNT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/sar_logic_ptr.sv
// -----------------------------------------------------------------------------
// sar_logic_ptr
// One-hot bit pointer for the successive-approximation search. It marks the
// bit currently under trial, starting at the MSB and walking toward the LSB.
// Ports:
//   cp      in  clock, rising edge
//   cdn     in  synchronous active-low reset (pointer cleared)
//   load    in  set the pointer to the MSB
//   shift   in  move the pointer one bit toward the LSB
//   ptr     out one-hot pointer
//   at_lsb  out pointer is on the LSB (last trial of the conversion)
// -----------------------------------------------------------------------------
module sar_logic_ptr #(
  parameter int NBITS = 8
) (
  input  logic             cp,
  input  logic             cdn,
  input  logic             load,
  input  logic             shift,
  output logic [NBITS-1:0] ptr,
  output logic             at_lsb
);

  localparam logic [NBITS-1:0] MSB_ONE = {1'b1, {(NBITS-1){1'b0}}};

  always_ff @(posedge cp) begin
    if (!cdn) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= MSB_ONE;
    end else if (shift) begin
      ptr <= ptr >> 1;
    end
  end

  assign at_lsb = ptr[0];

endmodule

// File: rtl/sar_logic.sv
// -----------------------------------------------------------------------------
// sar_logic
// Successive-approximation controller sitting between the comparator and the
// capacitive DAC. A conversion runs SAMPLE (track), then one SETTLE/COMPARE
// pair per bit MSB first, then a single DONE cycle that presents the result.
//
// Ports:
//   cp          in  clock, rising edge
//   cdn         in  synchronous active-low reset
//   start       in  conversion request, honoured in IDLE and DONE only
//   abort       in  drop the running conversion and return to IDLE
//   cmp         in  comparator decision (1 = vin >= vdac), used in COMPARE
//   sample_cfg  in  [3:0] sample length minus one (only with the macro below)
//   sample      out track/hold switch enable
//   cmp_en      out comparator strobe
//   dac_code    out trial code for the DAC
//   busy        out conversion in progress (SAMPLE/SETTLE/COMPARE)
//   done        out one-cycle completion pulse
//   result      out last completed conversion, held until the next done
//
// Build option: define SAR_LOGIC_SAMPLE_CFG_EN to add the sample_cfg port; the
// sample length then becomes sample_cfg+1 cycles, captured when start is
// accepted. Without it the length is the SAMPLE_CYCLES parameter.
// -----------------------------------------------------------------------------
module sar_logic
  import sar_logic_pkg::*;
#(
  parameter int NBITS         = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic             cp,
  input  logic             cdn,
  input  logic             start,
  input  logic             abort,
  input  logic             cmp,
`ifdef SAR_LOGIC_SAMPLE_CFG_EN
  input  logic [3:0]       sample_cfg,
`endif
  output logic             sample,
  output logic             cmp_en,
  output logic [NBITS-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] result
);

  localparam logic [NBITS-1:0] MSB_ONE = {1'b1, {(NBITS-1){1'b0}}};

  state_t                  state, state_next;
  logic [SAMPLE_CNT_W-1:0] sample_cnt, cnt_next, cnt_load;
  logic [NBITS-1:0]        dac_next, decided, ptr;
  logic                    at_lsb, ptr_load, ptr_shift, result_load;

  // The counter counts down to zero, so it is loaded with length-1.
`ifdef SAR_LOGIC_SAMPLE_CFG_EN
  assign cnt_load = sample_cfg;
`else
  localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_LOAD = SAMPLE_CNT_W'(SAMPLE_CYCLES - 1);
  assign cnt_load = SAMPLE_LOAD;
`endif

  sar_logic_ptr #(.NBITS(NBITS)) u_ptr (
    .cp     (cp),
    .cdn    (cdn),
    .load   (ptr_load),
    .shift  (ptr_shift),
    .ptr    (ptr),
    .at_lsb (at_lsb)
  );

  // Code after this trial's decision: a low comparator means the trial
  // overshot vin, so the pointed bit is dropped.
  assign decided = cmp ? dac_code : (dac_code & ~ptr);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_next  = state;
    dac_next    = dac_code;
    cnt_next    = sample_cnt;
    ptr_load    = 1'b0;
    ptr_shift   = 1'b0;
    result_load = 1'b0;

    unique case (state)
      IDLE: begin
        dac_next = '0;
        if (start && !abort) begin
          state_next = SAMPLE;
          cnt_next   = cnt_load;
        end
      end

      SAMPLE: begin
        if (abort) begin
          state_next = IDLE;
          dac_next   = '0;
        end else if (sample_cnt == '0) begin
          state_next = SETTLE;
          dac_next   = MSB_ONE;
          ptr_load   = 1'b1;
        end else begin
          cnt_next = sample_cnt - 1'b1;
        end
      end

      SETTLE: begin
        if (abort) begin
          state_next = IDLE;
          dac_next   = '0;
        end else begin
          state_next = COMPARE;
        end
      end

      COMPARE: begin
        if (abort) begin
          state_next = IDLE;
          dac_next   = '0;
        end else if (!at_lsb) begin
          state_next = SETTLE;
          dac_next   = decided | (ptr >> 1);
          ptr_shift  = 1'b1;
        end else begin
          state_next  = DONE;
          dac_next    = decided;
          result_load = 1'b1;
        end
      end

      DONE: begin
        dac_next = '0;
        if (start && !abort) begin
          state_next = SAMPLE;
          cnt_next   = cnt_load;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        dac_next   = '0;
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values; reset sits inside the clocked block (synchronous).
  always_ff @(posedge cp) begin
    if (!cdn) begin
      state      <= IDLE;
      dac_code   <= '0;
      result     <= '0;
      sample_cnt <= '0;
    end else begin
      state      <= state_next;
      dac_code   <= dac_next;
      sample_cnt <= cnt_next;
      if (result_load) begin
        result <= dac_next;
      end
    end
  end

  // Control outputs are pure decodes of the state register.
  assign sample = (state == SAMPLE);
  assign cmp_en = (state == COMPARE);
  assign busy   = (state == SAMPLE) || (state == SETTLE) || (state == COMPARE);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_sar_logic.sv
// -----------------------------------------------------------------------------
// tb_sar_logic
// Directed bench for sar_logic (NBITS=8, SAMPLE_CYCLES=2). The driver pushes
// the expected done cycle/result into a queue when it issues start; a monitor
// pops an entry whenever done is seen. An optional trial-code queue checks the
// DAC code in every SETTLE cycle of the traced conversion.
// Cycle numbering: if start is driven at the negedge where cyc == c, cycle n
// of the conversion is the negedge where cyc == c + n.
// -----------------------------------------------------------------------------
module tb_sar_logic;

  logic       cp, cdn, start, abort, cmp;
  logic       sample, cmp_en, busy, done;
  logic [7:0] dac_code, result;
`ifdef SAR_LOGIC_SAMPLE_CFG_EN
  logic [3:0] sample_cfg;
`endif

  // Comparator model: 0 = ideal against vin, 1 = stuck high, 2 = stuck low.
  logic [1:0] cmp_mode;
  logic [7:0] vin;
  assign cmp = (cmp_mode == 2'd0) ? (vin >= dac_code) : (cmp_mode == 2'd1);

  sar_logic #(.NBITS(8), .SAMPLE_CYCLES(2)) dut (
    .cp         (cp),
    .cdn        (cdn),
    .start      (start),
    .abort      (abort),
    .cmp        (cmp),
`ifdef SAR_LOGIC_SAMPLE_CFG_EN
    .sample_cfg (sample_cfg),
`endif
    .sample     (sample),
    .cmp_en     (cmp_en),
    .dac_code   (dac_code),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  initial begin
    cp = 1'b0;
    forever #5 cp = ~cp;
  end

  int unsigned cyc = 0;
  always @(posedge cp) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  res;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] trial_q[$];
  logic       trace_en;
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge cp);
  endtask

  // Monitor: outputs change on posedge, so they are sampled on negedge.
  always @(negedge cp) begin
    exp_t       e;
    logic [7:0] t;
    if (cdn && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no done (cyc %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("done_result", {24'd0, result}, {24'd0, e.res});
      end
    end
    if (trace_en && busy && !sample && !cmp_en) begin
      if (trial_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_settle: got code 0x%0h expected no further trial", dac_code);
      end else begin
        t = trial_q.pop_front();
        check("settle_code", {24'd0, dac_code}, {24'd0, t});
      end
    end
  end

  int unsigned c;

  initial begin
    cdn = 1'b0; start = 1'b0; abort = 1'b0;
    cmp_mode = 2'd0; vin = 8'h00; trace_en = 1'b0;
`ifdef SAR_LOGIC_SAMPLE_CFG_EN
    sample_cfg = 4'd1;
`endif

    // Power-on reset values.
    wait_cyc(3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sample", {31'd0, sample}, 32'd0);
    check("rst_cmp_en", {31'd0, cmp_en}, 32'd0);
    check("rst_dac", {24'd0, dac_code}, 32'h00);
    check("rst_result", {24'd0, result}, 32'h00);
    cdn = 1'b1;
    wait_cyc(2);

    // Reset mid-conversion: no done may follow.
    vin = 8'h77;
    start = 1'b1; wait_cyc(1); start = 1'b0;
    wait_cyc(6);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    cdn = 1'b0;
    wait_cyc(2);
    cdn = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_dac", {24'd0, dac_code}, 32'h00);
    wait_cyc(1);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_done", {31'd0, done}, 32'd0);
    check("post_rst_dac", {24'd0, dac_code}, 32'h00);
    check("post_rst_result", {24'd0, result}, 32'h00);
    wait_cyc(25);

    // Ideal comparator, vin = 0xA5, with the SETTLE trial sequence traced.
    vin = 8'hA5;
    trial_q = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    trace_en = 1'b1;
    c = cyc;
    exp_q.push_back('{c + 19, 8'hA5});
    start = 1'b1; wait_cyc(1); start = 1'b0;
    check("a5_sample", {31'd0, sample}, 32'd1);
    check("a5_sample_dac", {24'd0, dac_code}, 32'h00);
    wait_cyc(21);
    trace_en = 1'b0;
    check("a5_trials_left", trial_q.size(), 32'd0);

    // Stuck-high comparator.
    cmp_mode = 2'd1;
    c = cyc;
    exp_q.push_back('{c + 19, 8'hFF});
    start = 1'b1; wait_cyc(1); start = 1'b0;
    wait_cyc(21);

    // Stuck-low comparator.
    cmp_mode = 2'd2;
    c = cyc;
    exp_q.push_back('{c + 19, 8'h00});
    start = 1'b1; wait_cyc(1); start = 1'b0;
    wait_cyc(21);

    // Start pulsed again in cycle 5 is ignored.
    cmp_mode = 2'd0;
    vin = 8'h3C;
    c = cyc;
    exp_q.push_back('{c + 19, 8'h3C});
    start = 1'b1; wait_cyc(1); start = 1'b0;
    wait_cyc(4);
    start = 1'b1; wait_cyc(1); start = 1'b0;
    wait_cyc(16);

    // Abort in cycle 10 after a 0xA5 result.
    vin = 8'hA5;
    c = cyc;
    exp_q.push_back('{c + 19, 8'hA5});
    start = 1'b1; wait_cyc(1); start = 1'b0;
    wait_cyc(21);
    vin = 8'h12;
    start = 1'b1; wait_cyc(1); start = 1'b0;
    wait_cyc(9);
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1; wait_cyc(1); abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dac", {24'd0, dac_code}, 32'h00);
    check("abort_result", {24'd0, result}, 32'hA5);
    wait_cyc(15);
    check("abort_result_held", {24'd0, result}, 32'hA5);

    // Back-to-back: start held through the first DONE.
    vin = 8'h5A;
    c = cyc;
    exp_q.push_back('{c + 19, 8'h5A});
    exp_q.push_back('{c + 38, 8'h5A});
    start = 1'b1;
    wait_cyc(19);
    check("b2b_done_sample", {31'd0, sample}, 32'd0);
    wait_cyc(1);
    start = 1'b0;
    check("b2b_resample", {31'd0, sample}, 32'd1);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_cyc(21);
    check("b2b_idle", {31'd0, busy}, 32'd0);

`ifdef SAR_LOGIC_SAMPLE_CFG_EN
    // sample_cfg=5 gives six sample cycles; later changes are ignored.
    vin = 8'h33;
    sample_cfg = 4'd5;
    c = cyc;
    exp_q.push_back('{c + 23, 8'h33});
    start = 1'b1; wait_cyc(1); start = 1'b0;
    sample_cfg = 4'd0;
    check("cfg_sample_c1", {31'd0, sample}, 32'd1);
    wait_cyc(5);
    check("cfg_sample_c6", {31'd0, sample}, 32'd1);
    wait_cyc(1);
    check("cfg_sample_c7", {31'd0, sample}, 32'd0);
    check("cfg_busy_c7", {31'd0, busy}, 32'd1);
    wait_cyc(18);
`endif

    check("pending_done", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
